// File: rtl/value_writeback_hbm_pkg.sv
// Shared accelerator constants and types for the vertex value writeback path.
package value_writeback_hbm_pkg;

  localparam int unsigned VW_CORE_NUM       = 32;
  localparam int unsigned VW_V_VALUE_WIDTH  = 32;
  localparam int unsigned VW_V_VALUE_AWIDTH = 15;
  localparam int unsigned VW_HBM_DWIDTH     = 1024;
  localparam int unsigned VW_HBM_AWIDTH     = 64;
  localparam int unsigned VW_URAM_DELAY     = 4;
  localparam int unsigned VW_LINE_BYTES     = 128;
  localparam int unsigned VW_WB_FIFO_DEPTH  = 8;
  localparam logic [63:0] VW_WR_BASE_ADDR   = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_t;

endpackage

// File: rtl/value_writeback_hbm_fifo.sv
// Line buffer: synchronous first-word-fall-through FIFO. When empty, a
// pushed word is visible on the head in the same cycle and can be popped
// straight through without being stored.
module wb_line_fifo #(
  parameter int unsigned WIDTH = 1152,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty  = (r_count == '0);
  assign w_bypass = w_empty && i_push && i_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = i_pop && !w_empty;

  assign o_valid  = !w_empty || i_push;
  assign o_head   = w_empty ? i_data : r_mem[r_rptr];
  assign o_count  = r_count;

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_wr && !w_rd && (r_count == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(i_pop && !o_valid));

endmodule

// File: rtl/value_writeback_hbm.sv
// Drains per-core vertex value URAMs to HBM: broadcast reads, credit-limited
// line buffer, registered line-aligned HBM writes with valid/ready.
module value_writeback_hbm
  import value_writeback_hbm_pkg::*;
#(
  parameter int unsigned CORE_NUM       = VW_CORE_NUM,
  parameter int unsigned V_VALUE_WIDTH  = VW_V_VALUE_WIDTH,
  parameter int unsigned V_VALUE_AWIDTH = VW_V_VALUE_AWIDTH,
  parameter int unsigned HBM_DWIDTH     = VW_HBM_DWIDTH,
  parameter int unsigned HBM_AWIDTH     = VW_HBM_AWIDTH,
  parameter int unsigned URAM_DELAY     = VW_URAM_DELAY,
  parameter int unsigned FIFO_DEPTH     = VW_WB_FIFO_DEPTH,
  parameter logic [HBM_AWIDTH-1:0] WR_BASE_ADDR = HBM_AWIDTH'(VW_WR_BASE_ADDR)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [31:0]                         vertex_num,
  output logic [V_VALUE_AWIDTH-1:0]           uram_rd_addr,
  output logic                                uram_rd_valid,
  input  logic [CORE_NUM*V_VALUE_WIDTH-1:0]   uram_rd_data,
  input  logic [CORE_NUM-1:0]                 uram_rd_dvalid,
  output logic [HBM_AWIDTH-1:0]               hbm_wr_addr,
  output logic [HBM_DWIDTH-1:0]               hbm_wr_data,
  output logic [HBM_DWIDTH/8-1:0]             hbm_wr_strb,
  output logic                                hbm_wr_valid,
  input  logic                                hbm_wr_ready,
  output logic                                wb_busy,
  output logic                                wb_complete
);

  localparam int unsigned STRB_W     = HBM_DWIDTH / 8;
  localparam int unsigned LANE_BYTES = V_VALUE_WIDTH / 8;
  localparam int unsigned FIFO_W     = HBM_DWIDTH + STRB_W;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

  wb_state_t r_state;
  wb_state_t w_next;

  logic [31:0]     r_lines;
  logic [31:0]     r_last_lanes;
  logic [31:0]     r_rd_ct;
  logic [31:0]     r_push_ct;
  logic [31:0]     r_ld_ct;
  logic [CW-1:0]   r_inflight;

  logic [HBM_AWIDTH-1:0] r_wr_addr;
  logic [HBM_DWIDTH-1:0] r_wr_data;
  logic [STRB_W-1:0]     r_wr_strb;
  logic                  r_wr_valid;

  logic [31:0]       w_lines_in;
  logic [31:0]       w_last_lanes_in;
  logic              w_start_ok;
  logic              w_issue;
  logic              w_push;
  logic              w_last_push;
  logic              w_load;
  logic              w_drain_done;
  logic [HBM_DWIDTH-1:0] w_line_data;
  logic [STRB_W-1:0]     w_line_strb;
  logic [FIFO_W-1:0]     w_fifo_head;
  logic                  w_fifo_valid;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_unused;

  // Only lane 0 return valid is used; all lanes return in lockstep.
  assign w_unused = ^uram_rd_dvalid[CORE_NUM-1:1];

  // Split the division so vertex counts near 2^32 cannot overflow the round-up.
  assign w_lines_in      = (vertex_num / 32'(CORE_NUM))
                         + {31'b0, (vertex_num % 32'(CORE_NUM)) != 32'd0};
  assign w_last_lanes_in = vertex_num - (w_lines_in - 32'd1) * 32'(CORE_NUM);

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  assign w_issue = rst && (r_state == ST_RUN) && (r_rd_ct < r_lines)
                && ((32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH));

  assign w_push = uram_rd_dvalid[0]
               && ((r_state == ST_RUN) || (r_state == ST_DRAIN));

  assign w_last_push = (r_push_ct == (r_lines - 32'd1));

  assign w_load = w_fifo_valid && (!r_wr_valid || hbm_wr_ready);

  // True in the cycle the final beat leaves, so DONE follows acceptance by one cycle.
  assign w_drain_done = (r_inflight == '0) && (w_fifo_count == '0) && !w_push
                     && (!r_wr_valid || hbm_wr_ready);

  assign uram_rd_valid = w_issue;
  assign uram_rd_addr  = w_issue ? r_rd_ct[V_VALUE_AWIDTH-1:0] : '0;

  assign hbm_wr_addr  = r_wr_addr;
  assign hbm_wr_data  = r_wr_data;
  assign hbm_wr_strb  = r_wr_strb;
  assign hbm_wr_valid = r_wr_valid;

  assign wb_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign wb_complete = (r_state == ST_DONE);

  // Mask lanes beyond the vertex count on the final line.
  always_comb begin
    w_line_data = '0;
    w_line_strb = '0;
    for (int unsigned i = 0; i < CORE_NUM; i++) begin
      if (!w_last_push || (i < r_last_lanes)) begin
        w_line_data[i*V_VALUE_WIDTH +: V_VALUE_WIDTH] =
          uram_rd_data[i*V_VALUE_WIDTH +: V_VALUE_WIDTH];
        w_line_strb[i*LANE_BYTES +: LANE_BYTES] = '1;
      end
    end
  end

  wb_line_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_line_strb, w_line_data}),
    .i_pop   (w_load),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next = (w_lines_in != 32'd0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (r_rd_ct == r_lines) w_next = w_drain_done ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_done) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Job configuration, read issue and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lines      <= '0;
      r_last_lanes <= '0;
      r_rd_ct      <= '0;
      r_push_ct    <= '0;
      r_inflight   <= '0;
    end else if (w_start_ok) begin
      r_lines      <= w_lines_in;
      r_last_lanes <= w_last_lanes_in;
      r_rd_ct      <= '0;
      r_push_ct    <= '0;
      r_inflight   <= '0;
    end else begin
      if (w_issue) r_rd_ct   <= r_rd_ct + 32'd1;
      if (w_push)  r_push_ct <= r_push_ct + 32'd1;
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
    end
  end

  // HBM output register loaded from the FIFO head; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
      r_wr_valid <= 1'b0;
      r_ld_ct    <= '0;
    end else if (w_start_ok) begin
      r_ld_ct <= '0;
    end else if (w_load) begin
      r_wr_valid <= 1'b1;
      r_wr_data  <= w_fifo_head[HBM_DWIDTH-1:0];
      r_wr_strb  <= w_fifo_head[FIFO_W-1:HBM_DWIDTH];
      r_wr_addr  <= WR_BASE_ADDR
                  + HBM_AWIDTH'(r_ld_ct) * HBM_AWIDTH'(VW_LINE_BYTES);
      r_ld_ct    <= r_ld_ct + 32'd1;
    end else if (hbm_wr_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

endmodule
